lsu_memory_cycle: RTL
=====================

LSU_MEMORY_CYCLE -- requirements
Module: lsu_memory_cycle

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, giving the data memory size in 32-bit words; it is a power of two.
REQ-002 SHALL have parameter LATENCY, default 2, giving memory access cycles; legal range is 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have these inputs: in_valid 1 (instruction present); alu_result_in 32 (address/ALU value); store_data_in 32; pc_plus4_in 32; rd_addr_in 5; memRead_in 1; memWrite_in 1; regWrite_in 1; resultSrc_in 2; funct3_in 3 (access size/sign).
REQ-006 SHALL have these outputs: stall_out 1 (freeze upstream); out_valid 1; read_data_out 32; alu_result_out 32; pc_plus4_out 32; rd_addr_out 5; regWrite_out 1; resultSrc_out 2; misaligned_out 1.

Function
REQ-007 SHALL register all MEM/WB outputs; no output is combinational from inputs except stall_out.
REQ-008 SHALL use FSM states IDLE and BUSY; inputs are sampled only in IDLE with in_valid=1.
REQ-009 SHALL complete non-memory ops (memRead_in=memWrite_in=0) and misaligned ops in 1 cycle: accepted at T, out_valid=1 at T+1.
REQ-010 SHALL handle an aligned memory op accepted at T as follows:
- If LATENCY=1: complete at T+1 with no stall.
- Else: load a counter with LATENCY-1, enter BUSY, decrement each cycle, return to IDLE on the edge where the counter is 1; out_valid=1 at T+LATENCY.
REQ-011 SHALL drive stall_out=1 in the accept cycle when LATENCY>1, and in BUSY while the counter is >1 (LATENCY-1 cycles in total); otherwise 0.
REQ-012 SHALL ignore inputs while in BUSY.
REQ-013 SHALL keep out_valid high for exactly one cycle per accepted op; in all other cycles out_valid=0 and regWrite_out=0 (bubble).
REQ-014 SHALL decode funct3_in as follows:
- 000: byte, sign-extended.
- 001: half, sign-extended.
- 010: word.
- 100: byte, zero-extended.
- 101: half, zero-extended.
- Any other value: treated as word.
REQ-015 SHALL write a store at the completion edge using byte enables from funct3_in[1:0] and alu_result_in[1:0]:
- Byte stores write store_data_in[7:0] into the addressed lane.
- Half stores write store_data_in[15:0] into lane pair 0-1 or 2-3.
REQ-016 SHALL select load data from the word sampled at the completion edge, shifted by alu_result_in[1:0], then extended per REQ-014.
REQ-017 SHALL compute the word index as alu_result_in[31:2] modulo MEM_DEPTH, so out-of-range addresses wrap.
REQ-018 SHALL flag misalignment (half with addr[0]=1, word with addr[1:0]!=0) as follows:
- Suppress the memory write.
- Set read_data_out=0, regWrite_out=0, misaligned_out=1 alongside out_valid.
REQ-019 SHALL give priority to the write when memRead_in and memWrite_in are both 1; read_data_out=0 in that case.
REQ-020 SHALL set read_data_out=0 for non-load ops and pass alu_result, pc_plus4, rd_addr and resultSrc through unchanged.

Reset
REQ-021 SHALL, on reset=0, immediately force the following, independent of clk:
- State IDLE and counter 0.
- stall_out=0 and out_valid=0.
- All data outputs, regWrite_out and misaligned_out to 0.
REQ-022 SHALL abort an in-flight BUSY op on reset with no memory write; memory contents are not reset.

Structure
REQ-023 SHALL take the funct3 size/sign constants, the state enumeration and the default LATENCY from shared package lsu_pkg.
REQ-024 SHALL place storage in sub-module lsu_data_ram (MEM_DEPTH x 32, 4-bit byte-enable synchronous write, combinational read).

Verification
REQ-025 SHALL check, with LATENCY=1: SW 0xDEADBEEF to addr 0x10, then LW from 0x10 -> read_data_out=0xDEADBEEF one cycle later, stall_out never asserted.
REQ-026 SHALL check, with LATENCY=3: LB at addr 0x13 holding word 0x80FF7F01 -> stall_out high 2 cycles, out_valid at T+3, read_data_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-027 SHALL check: SH 0x1234 at 0x22 over word 0xAAAAAAAA -> word becomes 0x1234AAAA; LHU at 0x22 -> 0x00001234.
REQ-028 SHALL check: LW at 0x06 -> misaligned_out=1, regWrite_out=0, 1-cycle completion; SW at 0x06 -> memory unchanged.
REQ-029 SHALL check, with LATENCY=4: assert reset in the second BUSY cycle of SW to 0x40 -> all outputs 0 at once, word at 0x40 unchanged, next op accepted in IDLE.
REQ-030 SHALL check, with MEM_DEPTH=256: SW to 0x400 then LW from 0x000 -> same data (wrap).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: access-size codes,
// FSM states, the latched-operation record and byte-lane helper functions.
package lsu_pkg;

    localparam int LSU_DEFAULT_LATENCY = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd_addr;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
    } lsu_op_t;

    // Size codes other than byte/half are treated as full words.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a, 3'b000};
        case (f3)
            F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  r = {24'd0, sh[7:0]};
            F3_LHU:  r = {16'd0, sh[15:0]};
            F3_LW:   r = word;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_data_ram.sv
// Word-organised data memory with per-byte write enables and a
// combinational read port sharing the write address.
module lsu_data_ram #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [3:0]                   be,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    logic [31:0] mem_r [MEM_DEPTH];

    // Byte-lane write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/lsu_memory_cycle.sv
// MEM stage of the pipeline: multi-cycle data-memory access with stall,
// sub-word loads/stores, misalignment detection and registered MEM/WB outputs.
module lsu_memory_cycle
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = LSU_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] pc_plus4_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        regWrite_in,
    input  logic [1:0]  resultSrc_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic        out_valid,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] pc_plus4_out,
    output logic [4:0]  rd_addr_out,
    output logic        regWrite_out,
    output logic [1:0]  resultSrc_out,
    output logic        misaligned_out
);
    localparam int         AW          = $clog2(MEM_DEPTH);
    localparam logic       MULTI_CYCLE = (LATENCY > 1) ? 1'b1 : 1'b0;
    localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);

    lsu_state_e  state_r;
    logic [3:0]  cnt_r;
    lsu_op_t     op_r;
    lsu_op_t     in_op_s;
    lsu_op_t     cur_op_s;
    logic        accept_s;
    logic        mem_s;
    logic        mis_s;
    logic        fast_s;
    logic        done_s;
    logic        we_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;
    logic [31:0] load_s;

    // Work on the live inputs in IDLE and on the latched copy while BUSY
    always_comb begin
        in_op_s.addr       = alu_result_in;
        in_op_s.store_data = store_data_in;
        in_op_s.pc_plus4   = pc_plus4_in;
        in_op_s.rd_addr    = rd_addr_in;
        in_op_s.mem_read   = memRead_in;
        in_op_s.mem_write  = memWrite_in;
        in_op_s.reg_write  = regWrite_in;
        in_op_s.result_src = resultSrc_in;
        in_op_s.funct3     = funct3_in;
        if (state_r == ST_BUSY) begin
            cur_op_s = op_r;
        end else begin
            cur_op_s = in_op_s;
        end
        accept_s  = reset & in_valid & (state_r == ST_IDLE);
        mem_s     = cur_op_s.mem_read | cur_op_s.mem_write;
        mis_s     = mem_s & is_misaligned(cur_op_s.funct3[1:0], cur_op_s.addr[1:0]);
        fast_s    = ~mem_s | mis_s | ~MULTI_CYCLE;
        done_s    = (accept_s & fast_s) | ((state_r == ST_BUSY) & (cnt_r == 4'd1));
        we_s      = done_s & cur_op_s.mem_write & ~mis_s;
        be_s      = byte_enable(cur_op_s.funct3[1:0], cur_op_s.addr[1:0]);
        wdata_s   = store_lanes(cur_op_s.funct3[1:0], cur_op_s.store_data);
        stall_out = (accept_s & ~fast_s) | ((state_r == ST_BUSY) & (cnt_r > 4'd1));
    end

    // Load data; a store issued together with a read takes priority and returns zero
    always_comb begin
        if (cur_op_s.mem_read & ~cur_op_s.mem_write & ~mis_s) begin
            load_s = load_extend(rdata_s, cur_op_s.funct3, cur_op_s.addr[1:0]);
        end else begin
            load_s = 32'd0;
        end
    end

    lsu_data_ram #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (we_s),
        .be   (be_s),
        .addr (cur_op_s.addr[AW+1:2]),
        .wdata(wdata_s),
        .rdata(rdata_s)
    );

    // Access FSM and MEM/WB output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 4'd0;
            op_r           <= '0;
            out_valid      <= 1'b0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            pc_plus4_out   <= 32'd0;
            rd_addr_out    <= 5'd0;
            regWrite_out   <= 1'b0;
            resultSrc_out  <= 2'd0;
            misaligned_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !fast_s) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= CNT_LOAD;
                        op_r    <= in_op_s;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
            if (done_s) begin
                out_valid      <= 1'b1;
                read_data_out  <= load_s;
                alu_result_out <= cur_op_s.addr;
                pc_plus4_out   <= cur_op_s.pc_plus4;
                rd_addr_out    <= cur_op_s.rd_addr;
                regWrite_out   <= cur_op_s.reg_write & ~mis_s;
                resultSrc_out  <= cur_op_s.result_src;
                misaligned_out <= mis_s;
            end else begin
                out_valid      <= 1'b0;
                read_data_out  <= 32'd0;
                alu_result_out <= 32'd0;
                pc_plus4_out   <= 32'd0;
                rd_addr_out    <= 5'd0;
                regWrite_out   <= 1'b0;
                resultSrc_out  <= 2'd0;
                misaligned_out <= 1'b0;
            end
        end
    end

endmodule
